spi_master_gen: RTL and testbench
=================================

Name: spi_master_gen

Overview:
Parametrised successor to the team's single-byte SPI master. It runs one SPI transaction per req/ack handshake, full duplex: it shifts tx_data out on D and captures Q into rdata at the same time. Word width, SCLK divider and chip-select count are parameters. SPI mode (CPOL/CPHA) is selected per transfer, and a burst flag holds chip select asserted across consecutive words. It sits between the flash/peripheral command sequencers and the SPI pads.

Parameters:
DATA_W, 8, bits per transfer (>=2); shifted MSB first.
DIV, 2, system clocks per SCLK half-period (>=1).
NCS, 1, number of chip-select outputs (>=1).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
req  input  1  start request; sampled only in IDLE.
data  input  DATA_W  transmit word, latched when req is accepted.
cpol  input  1  SCLK idle level, latched when req is accepted.
cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched when req is accepted.
cs_sel  input  max(1,$clog2(NCS))  chip-select index, latched when req is accepted.
last  input  1  1 = release CS after this word; 0 = hold CS for a burst. Latched when req is accepted.
Q  input  1  serial data from slave (MISO).
ack  output  1  one-cycle done pulse; rdata is valid in the same cycle.
busy  output  1  high whenever the state is not IDLE.
D  output  1  serial data to slave (MOSI).
CLK  output  1  SCLK, registered.
cs_n  output  NCS  active-low chip selects, registered.
rdata  output  DATA_W  received word.

Behaviour:
- Reset (asynchronous, active-high) forces every output and all internal state to its reset value, including mid-transfer.
  - Reset values: state IDLE; CLK=0; cs_n all 1; D=0; rdata=0; ack=0; busy=0.
  - The latched cpol resets to 0.
- States: IDLE -> SETUP -> XFER -> HOLD -> ACK -> IDLE.
- IDLE:
  - req=1 latches data, cpol, cpha, cs_sel and last, then moves to SETUP.
  - req in any other state is ignored; there is no queueing.
  - CLK rests at the latched cpol.
- SETUP, DIV cycles:
  - cs_n[cs_sel] goes 0 on entry; all other cs_n bits are 1.
  - If CS was held from a previous burst word with a different cs_sel, the old CS is released on this same edge.
  - D = shift[MSB] throughout.
  - CLK = cpol.
- XFER, 2*DATA_W half-periods of DIV cycles each, half-period index h = 0..2*DATA_W-1:
  - CLK = ~cpol for even h and cpol for odd h. Entry to an even h is the leading edge; entry to an odd h is the trailing edge.
  - cpha=0: sample Q at each leading edge; shift tx left at each trailing edge except the last.
  - cpha=1: shift tx left at each leading edge except the first (h=0); sample Q at each trailing edge.
  - The rx shift register fills MSB first; exactly DATA_W samples are taken.
- HOLD, DIV cycles:
  - CLK = cpol.
  - At exit: if last=1, all cs_n go to 1; otherwise cs_n is held.
- ACK, 1 cycle: ack=1, rdata = rx shift register. rdata then holds until the next ACK.
- Latency: req sampled at edge t gives ack high in cycle t + DIV*(2*DATA_W+2) + 1.
- Back-to-back transfers: the earliest next req acceptance is the cycle after ACK.
- Counters:
  - Divider counter width is $clog2(DIV+1).
  - Half-period counter width is $clog2(2*DATA_W); it wraps only on return to IDLE.
- Edge cases:
  - DIV=1: CLK toggles every cycle during XFER.
  - A req arriving in the ACK cycle is ignored and must be re-presented.
  - cs_sel >= NCS: no cs_n asserts, but the transfer still runs and acks.

Optional Feature:
Macro: SPI_MASTER_LOOPBACK_EN.
- Defined: adds input port loop_en (1 bit). When loop_en=1, the sampled bit is the current D instead of Q, so rdata equals data. loop_en is latched when req is accepted.
- Not defined: the port is absent and Q is always sampled.

Test Plan:
1. DATA_W=8, DIV=2, cpol=0, cpha=0, data=8'hA5, slave drives 8'h3C, last=1 -> ack exactly 37 cycles after req is sampled; rdata=8'h3C; slave sees 8'hA5; 8 rising SCLK edges; cs_n returns to 1 after HOLD.
2. All four cpol/cpha combinations, data=8'h81, slave returns 8'h7E -> rdata=8'h7E each time; CLK idles at cpol before and after; sampling occurs on the edge defined for each cpha.
3. Burst of 3 words (last=0,0,1), data=8'h01,8'h02,8'h03 -> cs_n[0] stays 0 continuously from the first SETUP to the end of the third HOLD; 3 ack pulses.
4. NCS=4, cs_sel=2, then cs_sel=1 held burst switch -> cs_n=4'b1011, then 4'b1101 on the new SETUP entry; never two bits low at once.
5. Reset asserted at half-period 7 of XFER -> next cycle CLK=0, cs_n all 1, busy=0, ack=0, rdata=0; a fresh req afterwards completes normally.
6. req held high through ACK, and req pulsed during XFER -> only one transfer is started per acceptance in IDLE; with SPI_MASTER_LOOPBACK_EN and loop_en=1, data=8'hC3 -> rdata=8'hC3.

Source files
------------

// File: rtl/spi_master_gen.sv
// spi_master_gen: parametrised full-duplex SPI master, one word per req/ack handshake.
// Define SPI_MASTER_LOOPBACK_EN to add loop_en, which samples D instead of Q.
module spi_master_gen #(
    parameter int DATA_W = 8,
    parameter int DIV    = 2,
    parameter int NCS    = 1,
    localparam int CS_W  = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [DATA_W-1:0] data,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              last,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic              loop_en,
`endif
    input  logic              Q,
    output logic              ack,
    output logic              busy,
    output logic              D,
    output logic              CLK,
    output logic [NCS-1:0]    cs_n,
    output logic [DATA_W-1:0] rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_ACK
    } state_e;

    localparam int                DIV_W     = $clog2(DIV + 1);
    localparam int                HALF_W    = $clog2(2 * DATA_W);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

    state_e              state_q;
    logic [DIV_W-1:0]    div_q;
    logic [HALF_W-1:0]   half_q;
    logic [DATA_W-1:0]   tx_q;
    logic [DATA_W-1:0]   rx_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                cpol_q;
    logic                cpha_q;
    logic                last_q;
    logic                ack_q;
    logic                busy_q;
    logic                d_q;
    logic                sclk_q;
    logic [NCS-1:0]      cs_n_q;

    logic                div_done;
    logic                sample_bit;
    logic [HALF_W-1:0]   half_d;
    logic [DATA_W-1:0]   tx_d;
    logic [DATA_W-1:0]   rx_d;
    logic [NCS-1:0]      cs_n_d;

    assign div_done = (div_q == DIV_LAST);
    assign half_d   = half_q + 1'b1;
    assign tx_d     = {tx_q[DATA_W-2:0], 1'b0};
    assign rx_d     = {rx_q[DATA_W-2:0], sample_bit};

`ifdef SPI_MASTER_LOOPBACK_EN
    logic loop_en_q;
    assign sample_bit = loop_en_q ? d_q : Q;
`else
    assign sample_bit = Q;
`endif

    // Selecting a new chip select releases every other one on the same edge,
    // so a burst that switches targets never has two selects low.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        cs_n_d = '1;
        for (int i = 0; i < NCS; i++) begin
            if (cs_sel == CS_W'(i)) cs_n_d[i] = 1'b0;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            half_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            last_q    <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            d_q       <= 1'b0;
            sclk_q    <= 1'b0;
            cs_n_q    <= '1;
`ifdef SPI_MASTER_LOOPBACK_EN
            loop_en_q <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    sclk_q <= cpol_q;
                    div_q  <= '0;
                    half_q <= '0;
                    if (req) begin
                        tx_q      <= data;
                        cpol_q    <= cpol;
                        cpha_q    <= cpha;
                        last_q    <= last;
`ifdef SPI_MASTER_LOOPBACK_EN
                        loop_en_q <= loop_en;
`endif
                        d_q       <= data[DATA_W-1];
                        sclk_q    <= cpol;
                        cs_n_q    <= cs_n_d;
                        busy_q    <= 1'b1;
                        state_q   <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (div_done) begin
                        div_q   <= '0;
                        half_q  <= '0;
                        sclk_q  <= ~cpol_q;
                        if (!cpha_q) rx_q <= rx_d;
                        state_q <= S_XFER;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end

                // Even half-periods start on a leading edge, odd ones on a trailing
                // edge; sampling happens on the edge selected by cpha, shifting on
                // the other, and the final trailing edge never shifts.
                S_XFER: begin
                    if (div_done) begin
                        div_q <= '0;
                        if (half_q == HALF_LAST) begin
                            sclk_q  <= cpol_q;
                            state_q <= S_HOLD;
                        end else begin
                            half_q <= half_d;
                            sclk_q <= half_d[0] ? cpol_q : ~cpol_q;
                            if (half_d[0] == cpha_q) begin
                                rx_q <= rx_d;
                            end else if (half_d != HALF_LAST) begin
                                tx_q <= tx_d;
                                d_q  <= tx_d[DATA_W-1];
                            end
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end

                S_HOLD: begin
                    sclk_q <= cpol_q;
                    if (div_done) begin
                        div_q   <= '0;
                        if (last_q) cs_n_q <= '1;
                        ack_q   <= 1'b1;
                        rdata_q <= rx_q;
                        state_q <= S_ACK;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end

                S_ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack   = ack_q;
    assign busy  = busy_q;
    assign D     = d_q;
    assign CLK   = sclk_q;
    assign cs_n  = cs_n_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Self-checking bench for spi_master_gen: behavioural SPI slave plus a scoreboard
// of expected words popped on each ack.
module tb_spi_master_gen;

    localparam int DATA_W = 8;
    localparam int DIV    = 2;
    localparam int NCS    = 4;
    localparam int LAT    = DIV * (2 * DATA_W + 2) + 1;

    typedef struct packed {
        logic [7:0] rdata;
        logic [7:0] mosi;
        logic [3:0] cs;
        logic       last;
        logic       cpol;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [7:0]  data;
    logic        cpol;
    logic        cpha;
    logic [1:0]  cs_sel;
    logic        last;
    logic        Q = 1'b0;
    logic        ack;
    logic        busy;
    logic        D;
    logic        CLK;
    logic [3:0]  cs_n;
    logic [7:0]  rdata;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic        loop_en;
`endif

    int   n_checks = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   accepts  = 0;
    int   acks     = 0;
    int   two_low  = 0;
    int   cs0_breaks = 0;
    logic watch_cs0 = 1'b0;
    logic busy_prev = 1'b0;
    exp_t exp_q[$];

    // slave model state
    logic [7:0] slv_word = '0;
    logic [7:0] slv_sh   = '0;
    logic [7:0] slv_rx   = '0;
    logic [1:0] slv_sel  = '0;
    logic       slv_cpol = 1'b0;
    logic       slv_cpha = 1'b0;
    int         slv_gen  = 0;
    int         slv_seen = 0;
    int         slv_lead = 0;
    int         slv_trail = 0;
    logic       slv_csn;

    spi_master_gen #(.DATA_W(DATA_W), .DIV(DIV), .NCS(NCS)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .data   (data),
        .cpol   (cpol),
        .cpha   (cpha),
        .cs_sel (cs_sel),
        .last   (last),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loop_en(loop_en),
`endif
        .Q      (Q),
        .ack    (ack),
        .busy   (busy),
        .D      (D),
        .CLK    (CLK),
        .cs_n   (cs_n),
        .rdata  (rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign slv_csn = cs_n[slv_sel];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // SPI slave: drives Q and captures D on the edges its mode defines.
    always @(CLK or slv_gen) begin
        if (slv_gen != slv_seen) begin
            slv_seen  = slv_gen;
            slv_sh    = slv_word;
            slv_rx    = '0;
            slv_lead  = 0;
            slv_trail = 0;
            if (!slv_cpha) begin
                Q      = slv_sh[7];
                slv_sh = slv_sh << 1;
            end
        end else if (slv_csn === 1'b0) begin
            if (CLK !== slv_cpol) begin
                slv_lead++;
                if (slv_cpha) begin
                    Q      = slv_sh[7];
                    slv_sh = slv_sh << 1;
                end else begin
                    slv_rx = {slv_rx[6:0], D};
                end
            end else if (slv_trail < slv_lead) begin
                slv_trail++;
                if (slv_cpha) begin
                    slv_rx = {slv_rx[6:0], D};
                end else begin
                    Q      = slv_sh[7];
                    slv_sh = slv_sh << 1;
                end
            end
        end
    end

    // Monitor: acceptance, ack scoreboard, chip-select invariants.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (watch_cs0 && !ack && cs_n[0]) cs0_breaks++;
            if ($countones(~cs_n) > 1) two_low++;
            if (busy && !busy_prev) begin
                accepts++;
                acc_cyc = cyc;
                if (exp_q.size() > 0) begin
                    check("cs_setup", 32'(cs_n), 32'(exp_q[0].cs));
                    check("clk_setup", 32'(CLK), 32'(exp_q[0].cpol));
                end
            end
            if (ack) begin
                acks++;
                check("ack_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rdata", 32'(rdata), 32'(e.rdata));
                    check("slave_mosi", 32'(slv_rx), 32'(e.mosi));
                    check("latency", 32'(cyc - acc_cyc + 1), 32'(LAT));
                    check("lead_edges", 32'(slv_lead), 32'd8);
                    check("trail_edges", 32'(slv_trail), 32'd8);
                    check("cs_at_ack", 32'(cs_n), e.last ? 32'hF : 32'(e.cs));
                    check("clk_at_ack", 32'(CLK), 32'(e.cpol));
                end
            end
        end
        busy_prev = busy;
    end

    task automatic prep(input logic [7:0] w, input logic [7:0] s, input logic p,
                        input logic h, input logic [1:0] sel, input logic l, input logic lb);
        exp_t e;
        e.rdata = lb ? w : s;
        e.mosi  = w;
        e.cs    = ~(4'b0001 << sel);
        e.last  = l;
        e.cpol  = p;
        exp_q.push_back(e);
        slv_word = s;
        slv_sel  = sel;
        slv_cpol = p;
        slv_cpha = h;
        slv_gen++;
        data   = w;
        cpol   = p;
        cpha   = h;
        cs_sel = sel;
        last   = l;
`ifdef SPI_MASTER_LOOPBACK_EN
        loop_en = lb;
`endif
    endtask

    task automatic start();
        int a0;
        int n;
        a0 = accepts;
        n  = 0;
        @(negedge clk); #1;
        req = 1'b1;
        while (accepts == a0 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check("accepted", 32'(accepts != a0), 32'd1);
        req = 1'b0;
    endtask

    task automatic wait_ack(input int k0);
        int n;
        n = 0;
        while (acks == k0 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        check("ack_seen", 32'(acks != k0), 32'd1);
        if (acks == k0) exp_q.delete();
    endtask

    task automatic xfer(input logic [7:0] w, input logic [7:0] s, input logic p,
                        input logic h, input logic [1:0] sel, input logic l, input logic lb);
        int k0;
        prep(w, s, p, h, sel, l, lb);
        k0 = acks;
        start();
        wait_ack(k0);
    endtask

    initial begin
        int a0;
        int k0;
        int t;
        int n;
        logic prev;

        reset = 1'b1;
        req = 1'b0; data = '0; cpol = 1'b0; cpha = 1'b0; cs_sel = '0; last = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
        loop_en = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clk", 32'(CLK), 32'd0);
        check("rst_cs_n", 32'(cs_n), 32'hF);
        check("rst_d", 32'(D), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;

        // basic mode 0 transfer
        xfer(8'hA5, 8'h3C, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);

        // all four modes, idle level checked after each
        for (int m = 0; m < 4; m++) begin
            xfer(8'h81, 8'h7E, m[1], m[0], 2'd0, 1'b1, 1'b0);
            @(negedge clk); #1;
            check("clk_idle", 32'(CLK), 32'(m[1]));
            check("busy_idle", 32'(busy), 32'd0);
        end

        // three-word burst on cs 0
        k0 = acks;
        xfer(8'h01, 8'hE1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        watch_cs0 = 1'b1;
        xfer(8'h02, 8'hE2, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        xfer(8'h03, 8'hE3, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        watch_cs0 = 1'b0;
        check("burst_cs0_breaks", 32'(cs0_breaks), 32'd0);
        check("burst_acks", 32'(acks - k0), 32'd3);

        // held select switched mid-burst
        xfer(8'h5C, 8'h4B, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
        xfer(8'hC5, 8'hB4, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);

        // reset during half-period 7 of XFER
        prep(8'hF0, 8'h0F, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        start();
        prev = CLK;
        t = 0;
        n = 0;
        while (t < 8 && n < 100) begin
            @(negedge clk); #1;
            n++;
            if (CLK !== prev) begin
                t++;
                prev = CLK;
            end
        end
        check("rst_reached_h7", 32'(t), 32'd8);
        reset = 1'b1;
        #1;
        check("midrst_clk", 32'(CLK), 32'd0);
        check("midrst_cs_n", 32'(cs_n), 32'hF);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_rdata", 32'(rdata), 32'd0);
        exp_q.delete();
        @(negedge clk); #1;
        reset = 1'b0;
        xfer(8'h96, 8'h69, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0);

        // req held high through ACK: exactly one acceptance
        prep(8'h3C, 8'h99, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
        a0 = accepts;
        k0 = acks;
        @(negedge clk); #1;
        req = 1'b1;
        wait_ack(k0);
        @(negedge clk); #1;
        check("req_in_ack_ignored", 32'(busy), 32'd0);
        check("ack_one_cycle", 32'(ack), 32'd0);
        req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("held_req_accepts", 32'(accepts - a0), 32'd1);

        // req pulsed during XFER is ignored, data not relatched
        prep(8'h5A, 8'hA3, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        a0 = accepts;
        k0 = acks;
        start();
        repeat (10) @(negedge clk);
        #1;
        data = 8'hFF;
        req  = 1'b1;
        @(negedge clk); #1;
        req = 1'b0;
        wait_ack(k0);
        repeat (3) @(negedge clk);
        #1;
        check("pulse_req_accepts", 32'(accepts - a0), 32'd1);
        check("pulse_req_acks", 32'(acks - k0), 32'd1);

`ifdef SPI_MASTER_LOOPBACK_EN
        xfer(8'hC3, 8'h5A, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
        xfer(8'hC3, 8'h5A, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1);
`endif

        check("two_low_cycles", 32'(two_low), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
